// File: rtl/wb_arbiter.sv
// Writeback arbiter feeding a two-write-port register file.
//
// Three producers (bit 0 = ALU, 1 = MUL, 2 = LSU) hand results over valid/ready
// into one-entry buffers. Each cycle up to two buffered results are granted,
// round-robin, onto write ports 0 and 1. The two ports never carry the same
// destination in one cycle. All write-port outputs are registered.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   src_valid/src_ready [2:0]       per-source handshake
//   src_dest  [3*REG_AW-1:0]        per-source destination, slice i*REG_AW
//   src_data  [3*DATA_W-1:0]        per-source result, slice i*DATA_W
//   wb_stall                        freeze all grants
//   write0/1, num_write0/1_out,
//   data_write0/1_out               register-file write port groups
//   pend_mask [2**REG_AW-1:0]       registers with a buffered or in-flight write
//   perf_conflict_cnt [15:0]        same-destination conflict cycles
//
// Optional: define WB_PERF_EN to build the saturating conflict counter;
// otherwise perf_conflict_cnt is tied to zero.
module wb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             src_valid,
    output logic [2:0]             src_ready,
    input  logic [3*REG_AW-1:0]    src_dest,
    input  logic [3*DATA_W-1:0]    src_data,
    input  logic                   wb_stall,
    output logic                   write0,
    output logic                   write1,
    output logic [REG_AW-1:0]      num_write0_out,
    output logic [REG_AW-1:0]      num_write1_out,
    output logic [DATA_W-1:0]      data_write0_out,
    output logic [DATA_W-1:0]      data_write1_out,
    output logic [2**REG_AW-1:0]   pend_mask,
    output logic [15:0]            perf_conflict_cnt
);

    logic [2:0]        buf_v_q;
    logic [REG_AW-1:0] buf_dest_q [3];
    logic [DATA_W-1:0] buf_data_q [3];
    logic [1:0]        rr_q;

    logic              write0_q, write1_q;
    logic [REG_AW-1:0] num0_q, num1_q;
    logic [DATA_W-1:0] data0_q, data1_q;

    logic [2:0]        grant;
    logic              p0_found, p1_found;
    logic [1:0]        p0_src, p1_src, last_src, idx;
`ifdef WB_PERF_EN
    logic              conflict;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] a);
        return (a == 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    // Grant depends only on buffer state and rr, never on src_valid.
    always_comb begin
        grant    = 3'b000;
        p0_found = 1'b0;
        p1_found = 1'b0;
        p0_src   = 2'd0;
        p1_src   = 2'd0;
        idx      = rr_q;
`ifdef WB_PERF_EN
        conflict = 1'b0;
`endif
        if (!wb_stall) begin
            for (int k = 0; k < 3; k++) begin
                if (buf_v_q[idx]) begin
                    if (!p0_found) begin
                        p0_found   = 1'b1;
                        p0_src     = idx;
                        grant[idx] = 1'b1;
                    end else if (!p1_found) begin
                        if (buf_dest_q[idx] != buf_dest_q[p0_src]) begin
                            p1_found   = 1'b1;
                            p1_src     = idx;
                            grant[idx] = 1'b1;
                        end
`ifdef WB_PERF_EN
                        else begin
                            conflict = 1'b1;
                        end
`endif
                    end
                end
                idx = inc3(idx);
            end
        end
        last_src = p1_found ? p1_src : p0_src;
    end

    // Grant is already zero under stall, so this reduces to !buf_v there.
    assign src_ready = ~buf_v_q | grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v_q  <= 3'b000;
            rr_q     <= 2'd0;
            write0_q <= 1'b0;
            write1_q <= 1'b0;
            num0_q   <= '0;
            num1_q   <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_dest_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            // Refill takes priority over drain so a same-edge swap loses nothing.
            for (int i = 0; i < 3; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    buf_v_q[i]    <= 1'b1;
                    buf_dest_q[i] <= src_dest[i*REG_AW +: REG_AW];
                    buf_data_q[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    buf_v_q[i] <= 1'b0;
                end
            end
            write0_q <= p0_found;
            write1_q <= p1_found;
            if (p0_found) begin
                num0_q  <= buf_dest_q[p0_src];
                data0_q <= buf_data_q[p0_src];
            end
            if (p1_found) begin
                num1_q  <= buf_dest_q[p1_src];
                data1_q <= buf_data_q[p1_src];
            end
            if (p0_found) begin
                rr_q <= inc3(last_src);
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 3; i++) begin
            if (buf_v_q[i]) begin
                pend_mask[buf_dest_q[i]] = 1'b1;
            end
        end
        if (write0_q) begin
            pend_mask[num0_q] = 1'b1;
        end
        if (write1_q) begin
            pend_mask[num1_q] = 1'b1;
        end
    end

    assign write0          = write0_q;
    assign write1          = write1_q;
    assign num_write0_out  = num0_q;
    assign num_write1_out  = num1_q;
    assign data_write0_out = data0_q;
    assign data_write1_out = data1_q;

`ifdef WB_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 16'h0000;
        end else if (conflict && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'h0001;
        end
    end

    assign perf_conflict_cnt = perf_q;
`else
    assign perf_conflict_cnt = 16'h0000;
`endif

endmodule
